// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_arb_pkg
//  Purpose  : Shared widths, types, state encoding and helpers for rom_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int RGB_W  = 12;

    typedef logic [ADDR_W-1:0] rom_addr_t;
    typedef logic [RGB_W-1:0]  rgb_t;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Next requester index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rom_arb_pick
//  Purpose  : One-hot picker; first asserted request at or after ptr, wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(ptr) + i) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom_arbiter
//  Purpose  : Round-robin (or fixed-priority with ROM_ARB_FIXED_PRIO_EN)
//             arbiter sharing one image ROM, with lockable bursts and a
//             latency-matched response pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  rom_addr_t [NUM_REQ-1:0]  addr,
    output logic [NUM_REQ-1:0]       gnt,
    output rom_addr_t                rom_addr,
    input  rgb_t                     rom_rgb,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output rgb_t                     rsp_rgb
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e            r_state;
    logic [PTR_W-1:0]      r_owner;
    logic [PTR_W-1:0]      w_ptr;
    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [PTR_W-1:0]      w_gidx;
    logic                  w_gvalid;
    logic                  w_lock_exit;

    logic [ROM_LATENCY-1:0] r_pv;
    logic [PTR_W-1:0]       r_pidx [ROM_LATENCY];
    rgb_t                   r_rgb_hold;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [PTR_W-1:0] r_ptr;
    assign w_ptr = r_ptr;
`endif

    rom_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (w_ptr),
        .gnt (w_pick_gnt)
    );

    // While locked only the owner may be granted; everyone else waits.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            if (r_state == LOCKED) begin
                if (req[r_owner]) gnt[r_owner] = 1'b1;
            end else begin
                gnt = w_pick_gnt;
            end
        end
    end

    always_comb begin
        w_gidx   = '0;
        rom_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                w_gidx   = i[PTR_W-1:0];
                rom_addr = addr[i];
            end
        end
    end

    assign w_gvalid    = |gnt;
    assign w_lock_exit = !req[r_owner] || !lock[r_owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_owner <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_gvalid && lock[w_gidx]) begin
                        r_state <= LOCKED;
                        r_owner <= w_gidx;
                    end
                end
                LOCKED: begin
                    if (w_lock_exit) r_state <= ARB;
                end
                default: r_state <= ARB;
            endcase
        end
    end

`ifndef ROM_ARB_FIXED_PRIO_EN
    // Pointer moves past each ARB grant, and past the owner when a lock ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state == ARB) begin
            if (w_gvalid) r_ptr <= PTR_W'(wrap_inc(int'(w_gidx), NUM_REQ));
        end else if (w_lock_exit) begin
            r_ptr <= PTR_W'(wrap_inc(int'(r_owner), NUM_REQ));
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv[0]   <= 1'b0;
            r_pidx[0] <= '0;
        end else begin
            r_pv[0]   <= w_gvalid;
            r_pidx[0] <= w_gidx;
        end
    end

    generate
        for (genvar s = 1; s < ROM_LATENCY; s++) begin : g_pipe_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv[s]   <= 1'b0;
                    r_pidx[s] <= '0;
                end else begin
                    r_pv[s]   <= r_pv[s-1];
                    r_pidx[s] <= r_pidx[s-1];
                end
            end
        end
    endgenerate

    // Response data is the live ROM output when due, otherwise the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb_hold <= '0;
        end else if (r_pv[ROM_LATENCY-1]) begin
            r_rgb_hold <= rom_rgb;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_pv[ROM_LATENCY-1]) rsp_valid[r_pidx[ROM_LATENCY-1]] = 1'b1;
    end

    assign rsp_rgb = r_pv[ROM_LATENCY-1] ? rom_rgb : r_rgb_hold;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_arbiter
//  Purpose  : Directed table-driven bench for rom_arbiter (4 requesters,
//             ROM latency 1); ROM model returns addr + 12'hF3F.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req;
    logic [3:0]        lock;
    logic [3:0][11:0]  addr;
    logic [3:0]        gnt;
    logic [11:0]       rom_addr;
    logic [11:0]       rom_rgb = 12'h000;
    logic [3:0]        rsp_valid;
    logic [11:0]       rsp_rgb;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  gnt;
        logic [11:0] ra;
        logic [3:0]  rv;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[$];

    rom_arbiter #(
        .NUM_REQ     (4),
        .ROM_LATENCY (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .addr      (addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_rgb   (rom_rgb),
        .rsp_valid (rsp_valid),
        .rsp_rgb   (rsp_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rgb <= rom_addr + 12'hF3F;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g,
                       input logic [11:0] ra, input logic [3:0] rv, input logic [11:0] rgb);
        vec_t v;
        v.req = r; v.lock = l; v.gnt = g; v.ra = ra; v.rv = rv; v.rgb = rgb;
        tbl.push_back(v);
    endtask

    task automatic run_row(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        req  = v.req;
        lock = v.lock;
        @(negedge clk);
        chk({tag, " gnt"},       32'(gnt),       32'(v.gnt));
        chk({tag, " rom_addr"},  32'(rom_addr),  32'(v.ra));
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.rv));
        chk({tag, " rsp_rgb"},   32'(rsp_rgb),   32'(v.rgb));
    endtask

    initial begin
        vec_t v;
        addr[0] = 12'h010;
        addr[1] = 12'h020;
        addr[2] = 12'h041;
        addr[3] = 12'h080;

`ifdef ROM_ARB_FIXED_PRIO_EN
        add(4'b1010, 4'b0000, 4'b0010, 12'h020, 4'b0000, 12'h000);
        add(4'b1010, 4'b0000, 4'b0010, 12'h020, 4'b0010, 12'hF5F);
        add(4'b1010, 4'b0000, 4'b0010, 12'h020, 4'b0010, 12'hF5F);
        add(4'b1010, 4'b0000, 4'b0010, 12'h020, 4'b0010, 12'hF5F);
        add(4'b1011, 4'b0001, 4'b0001, 12'h010, 4'b0010, 12'hF5F);
        add(4'b1011, 4'b0001, 4'b0001, 12'h010, 4'b0001, 12'hF4F);
        add(4'b1010, 4'b0000, 4'b0000, 12'h000, 4'b0001, 12'hF4F);
        add(4'b1010, 4'b0000, 4'b0010, 12'h020, 4'b0000, 12'hF4F);
        add(4'b0000, 4'b0000, 4'b0000, 12'h000, 4'b0010, 12'hF5F);
`else
        // Round-robin from reset: 0,1,2,3,0,1,2,3 with responses one cycle later
        add(4'b1111, 4'b0000, 4'b0001, 12'h010, 4'b0000, 12'h000);
        add(4'b1111, 4'b0000, 4'b0010, 12'h020, 4'b0001, 12'hF4F);
        add(4'b1111, 4'b0000, 4'b0100, 12'h041, 4'b0010, 12'hF5F);
        add(4'b1111, 4'b0000, 4'b1000, 12'h080, 4'b0100, 12'hF80);
        add(4'b1111, 4'b0000, 4'b0001, 12'h010, 4'b1000, 12'hFBF);
        add(4'b1111, 4'b0000, 4'b0010, 12'h020, 4'b0001, 12'hF4F);
        add(4'b1111, 4'b0000, 4'b0100, 12'h041, 4'b0010, 12'hF5F);
        add(4'b1111, 4'b0000, 4'b1000, 12'h080, 4'b0100, 12'hF80);
        add(4'b0000, 4'b0000, 4'b0000, 12'h000, 4'b1000, 12'hFBF);
        add(4'b0000, 4'b0000, 4'b0000, 12'h000, 4'b0000, 12'hFBF);
        // Single requester 2
        add(4'b0100, 4'b0000, 4'b0100, 12'h041, 4'b0000, 12'hFBF);
        add(4'b0000, 4'b0000, 4'b0000, 12'h000, 4'b0100, 12'hF80);
        // Wrap: pointer 3, req 0011
        add(4'b0011, 4'b0000, 4'b0001, 12'h010, 4'b0000, 12'hF80);
        // Lock burst by requester 1 for 5 cycles, requester 0 waiting
        add(4'b0011, 4'b0010, 4'b0010, 12'h020, 4'b0001, 12'hF4F);
        add(4'b0011, 4'b0010, 4'b0010, 12'h020, 4'b0010, 12'hF5F);
        add(4'b0011, 4'b0010, 4'b0010, 12'h020, 4'b0010, 12'hF5F);
        add(4'b0011, 4'b0010, 4'b0010, 12'h020, 4'b0010, 12'hF5F);
        add(4'b0011, 4'b0010, 4'b0010, 12'h020, 4'b0010, 12'hF5F);
        add(4'b0001, 4'b0000, 4'b0000, 12'h000, 4'b0010, 12'hF5F);
        // Pointer is now 2: requester 3 wins over 0
        add(4'b1001, 4'b0000, 4'b1000, 12'h080, 4'b0000, 12'hF5F);
        add(4'b0001, 4'b0000, 4'b0001, 12'h010, 4'b1000, 12'hFBF);
        add(4'b0000, 4'b0000, 4'b0000, 12'h000, 4'b0001, 12'hF4F);
        // Lock dropped while req held: exit cycle still grants owner
        add(4'b0100, 4'b0100, 4'b0100, 12'h041, 4'b0000, 12'hF4F);
        add(4'b0101, 4'b0000, 4'b0100, 12'h041, 4'b0100, 12'hF80);
        add(4'b0101, 4'b0000, 4'b0001, 12'h010, 4'b0100, 12'hF80);
        add(4'b0000, 4'b0000, 4'b0000, 12'h000, 4'b0001, 12'hF4F);
`endif

        // Reset state with requests present
        rst_n = 1'b0;
        req   = 4'b1111;
        lock  = 4'b0000;
        #12;
        chk("reset gnt",       32'(gnt),       32'h0);
        chk("reset rom_addr",  32'(rom_addr),  32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_rgb",   32'(rsp_rgb),   32'h0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_row($sformatf("row%0d", i), tbl[i]);
        end

        // Reset half a cycle after a grant: the read must never respond
        @(posedge clk);
        #1;
        req  = 4'b0001;
        lock = 4'b0000;
        @(negedge clk);
        chk("preflight gnt", 32'(gnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst gnt",       32'(gnt),       32'h0);
        chk("midrst rom_addr",  32'(rom_addr),  32'h0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst rsp_rgb",   32'(rsp_rgb),   32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d rsp_valid", i), 32'(rsp_valid), 32'h0);
            chk($sformatf("postrst%0d rsp_rgb", i),   32'(rsp_rgb),   32'h0);
        end
        v.req = 4'b1111; v.lock = 4'b0000; v.gnt = 4'b0001;
        v.ra = 12'h010; v.rv = 4'b0000; v.rgb = 12'h000;
        run_row("postrst ptr", v);
        v.req = 4'b0000; v.lock = 4'b0000; v.gnt = 4'b0000;
        v.ra = 12'h000; v.rv = 4'b0001; v.rgb = 12'hF4F;
        run_row("postrst rsp", v);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter ROM_LATENCY, default 1, giving the ROM read latency in clk cycles (1..3).
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req  input  NUM_REQ  per-requester read request.
REQ-006 The block SHALL have port lock  input  NUM_REQ  per-requester burst hold; meaningful only while that requester is granted.
REQ-007 The block SHALL have port addr  input  NUM_REQ x 12  per-requester ROM address {y[5:0], x[5:0]}.
REQ-008 The block SHALL have port gnt  output  NUM_REQ  one-hot grant, combinational in the request cycle.
REQ-009 The block SHALL have port rom_addr  output  12  address to the shared image ROM.
REQ-010 The block SHALL have port rom_rgb  input  12  ROM data {r, g, b}, valid ROM_LATENCY cycles after rom_addr.
REQ-011 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot, pulses for one cycle when rsp_rgb belongs to that requester.
REQ-012 The block SHALL have port rsp_rgb  output  12  returned pixel data.

Function
REQ-013 The arbiter SHALL use two states: ARB (select among active requests) and LOCKED (grant held by the owner).
REQ-014 In ARB, gnt SHALL select the first asserted req at or after the round-robin pointer, wrapping from NUM_REQ-1 to 0.
REQ-015 After each grant in ARB, the pointer SHALL advance to (granted index + 1) mod NUM_REQ at the next edge.
REQ-016 At most one gnt bit SHALL be high; gnt SHALL be 0 when req is 0.
REQ-017 rom_addr SHALL equal addr of the granted requester, and 12'h000 when no grant is active.
REQ-018 A grant with lock asserted in ARB SHALL move the state to LOCKED with the owner recorded.
REQ-019 In LOCKED, gnt SHALL go only to the owner while its req is high; other requests SHALL wait.
REQ-020 The block SHALL leave LOCKED for ARB at the first cycle the owner has req=0 or lock=0; that cycle's grant follows the LOCKED rule; the pointer then moves to owner+1.
REQ-021 One read SHALL be accepted per cycle; throughput is one pixel per clk.
REQ-022 A granted cycle at t SHALL produce rsp_valid[owner]=1 and rsp_rgb=rom_rgb at cycle t+ROM_LATENCY, tracked by a ROM_LATENCY-deep valid/index shift pipeline.
REQ-023 When no response is due, rsp_valid SHALL be 0 and rsp_rgb SHALL hold its last value.
REQ-024 Requests deasserted before a grant SHALL be dropped without any response; req and addr need not be held.

Reset
REQ-025 On rst_n low, asynchronously: state ARB, pointer 0, owner 0, pipeline cleared, rsp_valid 0, rsp_rgb 12'h000.
REQ-026 Reads in flight at reset SHALL be discarded; no rsp_valid SHALL pulse for them after release.
REQ-027 During reset, gnt SHALL be 0 and rom_addr SHALL be 12'h000.

Configuration
REQ-028 With ROM_ARB_FIXED_PRIO_EN defined, ARB SHALL grant the lowest-index active requester (index 0 highest) and the pointer SHALL be omitted; LOCKED behaviour is unchanged.
REQ-029 Without ROM_ARB_FIXED_PRIO_EN, round-robin per REQ-014/015 SHALL apply.

Structure
REQ-030 Package rom_arb_pkg SHALL hold ADDR_W=12, RGB_W=12, typedef rom_addr_t, typedef rgb_t and the state enum arb_state_e {ARB, LOCKED}.
REQ-031 The one-hot picker SHALL be a sub-module rom_arb_pick (request vector and pointer in, one-hot grant out); pipeline and FSM stay in rom_arbiter.

Verification
REQ-032 Single requester: req[2]=1, addr[2]=12'h041 at t, ROM returns 12'hF80 -> gnt=4'b0100 at t, rsp_valid=4'b0100 and rsp_rgb=12'hF80 at t+1.
REQ-033 Round-robin: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, one rsp per cycle in the same order.
REQ-034 Lock burst: req[1] and lock[1] high for 5 cycles, req[0] high throughout -> gnt[1] for 5 cycles, then gnt[0]; pointer = 2 afterwards.
REQ-035 Wrap: pointer=3, req=4'b0011 -> gnt=4'b0001.
REQ-036 Reset mid-flight: grant at t, rst_n low at t+0.5 for 2 cycles -> no rsp_valid after release, outputs at REQ-025 values.
REQ-037 With ROM_ARB_FIXED_PRIO_EN and req=4'b1010 held -> gnt=4'b0010 every cycle, requester 3 never served.
